// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline hazard controller. Produces per-stage stall/flush
//             enables from stall, redirect and exception requests, and runs
//             a RUN/DRAIN/SLEEP/WAKE low-power sequencer for WFI. Also keeps
//             a stall-timeout watchdog and a saturating stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] redirect_req,
  input  logic                  excp_flag,
  input  logic                  wfi_req,
  input  logic [NUM_STAGES-1:0] stage_valid,
  input  logic                  irq_pending,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [1:0]            ctrl_state,
  output logic                  timeout_pulse,
  output logic [31:0]           stall_cycles
);

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_DRAIN = 2'd1;
  localparam logic [1:0] c_SLEEP = 2'd2;
  localparam logic [1:0] c_WAKE  = 2'd3;

  localparam int              c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_nextState;
  logic [c_CNT_W-1:0]    r_toCnt;
  logic                  r_timeoutPulse;
  logic [31:0]           r_stallCycles;

  logic [NUM_STAGES-1:0] w_reqEff;
  logic [NUM_STAGES-1:0] w_stallRaw;
  logic [NUM_STAGES-1:0] w_redirFlush;
  logic [NUM_STAGES-1:0] w_runStall;
  logic [NUM_STAGES-1:0] w_bubble;
  logic [NUM_STAGES-1:0] w_runFlush;

  // Stage 0 never matters for sleep entry: it is held and bubbled in DRAIN.
  logic w_unused;
  assign w_unused = stage_valid[0];

  // Normal-flow hazard resolution: an older stall holds every younger
  // register, a redirect flushes everything younger and beats the stall,
  // and a bubble goes in just above the (post-redirect) stall boundary.
  // DRAIN reuses this with fetch forcibly held so older stages keep moving.
  always_comb begin
    w_reqEff = stall_req;
    if (r_state == c_DRAIN) begin
      w_reqEff[0] = 1'b1;
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_stallRaw[k]   = |(w_reqEff >> k);
      w_redirFlush[k] = |(redirect_req >> (k + 1));
    end
    w_runStall  = w_stallRaw & ~w_redirFlush;
    w_bubble    = '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      w_bubble[k] = w_runStall[k-1] & ~w_runStall[k];
    end
    w_runFlush = w_redirFlush | w_bubble;
  end

  // Final stall/flush selection: reset and exception dominate, then state.
  always_comb begin
    stall = '0;
    flush = '0;
    if (rst || excp_flag) begin
      flush = '1;
    end else begin
      case (r_state)
        c_RUN: begin
          stall = w_runStall;
          flush = w_runFlush;
        end
        c_DRAIN: begin
          stall    = w_runStall;
          flush    = w_runFlush;
          flush[1] = 1'b1;
        end
        c_SLEEP: begin
          stall = '1;
        end
        default: begin
          flush[0] = 1'b1;
        end
      endcase
    end
  end

  // Sequencer next-state: an interrupt in DRAIN skips SLEEP entirely.
  always_comb begin
    w_nextState = r_state;
    if (excp_flag) begin
      w_nextState = c_RUN;
    end else begin
      case (r_state)
        c_RUN: begin
          if (wfi_req) w_nextState = c_DRAIN;
        end
        c_DRAIN: begin
          if (irq_pending) begin
            w_nextState = c_WAKE;
          end else if (stage_valid[NUM_STAGES-1:1] == '0) begin
            w_nextState = c_SLEEP;
          end
        end
        c_SLEEP: begin
          if (irq_pending) w_nextState = c_WAKE;
        end
        default: begin
          w_nextState = c_RUN;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Watchdog: counts consecutive RUN cycles with fetch held and pulses on
  // the cycle after the TIMEOUT-th one, restarting from zero.
  always_ff @(posedge clk) begin
    if (rst || excp_flag || (r_state != c_RUN) || !stall[0]) begin
      r_toCnt        <= '0;
      r_timeoutPulse <= 1'b0;
    end else if (r_toCnt == c_CNT_LAST) begin
      r_toCnt        <= '0;
      r_timeoutPulse <= 1'b1;
    end else begin
      r_toCnt        <= r_toCnt + 1'b1;
      r_timeoutPulse <= 1'b0;
    end
  end

  // Saturating count of every cycle that holds fetch, in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCycles <= '0;
    end else if (stall[0] && (r_stallCycles != 32'hFFFF_FFFF)) begin
      r_stallCycles <= r_stallCycles + 32'd1;
    end
  end

  assign ctrl_state    = r_state;
  assign timeout_pulse = r_timeoutPulse;
  assign stall_cycles  = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Directed self-checking bench for pipe_ctrl (5 stages,
//             TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] stall_req;
  logic [4:0] redirect_req;
  logic       excp_flag;
  logic       wfi_req;
  logic [4:0] stage_valid;
  logic       irq_pending;
  logic [4:0] stall;
  logic [4:0] flush;
  logic [1:0] ctrl_state;
  logic       timeout_pulse;
  logic [31:0] stall_cycles;

  int nTests = 0;
  int nFail  = 0;

  pipe_ctrl #(.NUM_STAGES(5), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .redirect_req (redirect_req),
    .excp_flag    (excp_flag),
    .wfi_req      (wfi_req),
    .stage_valid  (stage_valid),
    .irq_pending  (irq_pending),
    .stall        (stall),
    .flush        (flush),
    .ctrl_state   (ctrl_state),
    .timeout_pulse(timeout_pulse),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    #1;
    nTests++; if (ctrl_state !== 2'd0) begin nFail++; $display("FAIL reset_state got=%0d exp=0", ctrl_state); end
    nTests++; if (stall !== 5'b00000) begin nFail++; $display("FAIL reset_stall got=%b exp=00000", stall); end
    nTests++; if (flush !== 5'b11111) begin nFail++; $display("FAIL reset_flush got=%b exp=11111", flush); end
    nTests++; if (timeout_pulse !== 1'b0) begin nFail++; $display("FAIL reset_pulse got=%b exp=0", timeout_pulse); end
    nTests++; if (stall_cycles !== 32'd0) begin nFail++; $display("FAIL reset_cycles got=%0d exp=0", stall_cycles); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stall_boundary();
    stall_req = 5'b00100;
    #1;
    nTests++; if (stall !== 5'b00111) begin nFail++; $display("FAIL boundary_stall got=%b exp=00111", stall); end
    nTests++; if (flush !== 5'b01000) begin nFail++; $display("FAIL boundary_flush got=%b exp=01000", flush); end
    stall_req = 5'b10000;
    #1;
    nTests++; if (stall !== 5'b11111) begin nFail++; $display("FAIL oldest_stall got=%b exp=11111", stall); end
    nTests++; if (flush !== 5'b00000) begin nFail++; $display("FAIL oldest_flush got=%b exp=00000", flush); end
    stall_req = 5'b00000;
    #1;
    nTests++; if ((stall !== 5'b00000) || (flush !== 5'b00000)) begin
      nFail++; $display("FAIL idle_run got stall=%b flush=%b exp 00000/00000", stall, flush);
    end
  endtask

  task automatic test_redirect();
    tick();
    stall_req    = 5'b00100;
    redirect_req = 5'b01000;
    #1;
    nTests++; if (flush !== 5'b00111) begin nFail++; $display("FAIL redir_flush got=%b exp=00111", flush); end
    nTests++; if (stall !== 5'b00000) begin nFail++; $display("FAIL redir_stall got=%b exp=00000", stall); end
    stall_req    = 5'b00000;
    redirect_req = 5'b10100;
    #1;
    nTests++; if (flush !== 5'b01111) begin nFail++; $display("FAIL multi_redir_flush got=%b exp=01111", flush); end
    nTests++; if (stall !== 5'b00000) begin nFail++; $display("FAIL multi_redir_stall got=%b exp=00000", stall); end
    redirect_req = 5'b00000;
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall_req = 5'b00001;
    tick(); tick(); tick();
    nTests++; if (timeout_pulse !== 1'b0) begin nFail++; $display("FAIL to_early got=%b exp=0", timeout_pulse); end
    tick();
    nTests++; if (timeout_pulse !== 1'b1) begin nFail++; $display("FAIL to_first got=%b exp=1", timeout_pulse); end
    nTests++; if (stall_cycles !== 32'd4) begin nFail++; $display("FAIL to_cycles4 got=%0d exp=4", stall_cycles); end
    tick();
    nTests++; if (timeout_pulse !== 1'b0) begin nFail++; $display("FAIL to_oneshot got=%b exp=0", timeout_pulse); end
    tick(); tick(); tick();
    nTests++; if (timeout_pulse !== 1'b1) begin nFail++; $display("FAIL to_second got=%b exp=1", timeout_pulse); end
    nTests++; if (stall_cycles !== 32'd8) begin nFail++; $display("FAIL to_cycles8 got=%0d exp=8", stall_cycles); end
    stall_req = 5'b00000;
    tick();
  endtask

  task automatic test_wfi_sleep();
    stage_valid = 5'b11110;
    wfi_req     = 1'b1;
    tick();
    wfi_req = 1'b0;
    nTests++; if (ctrl_state !== 2'd1) begin nFail++; $display("FAIL drain_enter got=%0d exp=1", ctrl_state); end
    nTests++; if ((stall !== 5'b00001) || (flush !== 5'b00010)) begin
      nFail++; $display("FAIL drain_ctrl got stall=%b flush=%b exp 00001/00010", stall, flush);
    end
    tick();
    nTests++; if (ctrl_state !== 2'd1) begin nFail++; $display("FAIL drain_2 got=%0d exp=1", ctrl_state); end
    tick();
    nTests++; if (ctrl_state !== 2'd1) begin nFail++; $display("FAIL drain_3 got=%0d exp=1", ctrl_state); end
    stage_valid = 5'b00000;
    tick();
    nTests++; if (ctrl_state !== 2'd2) begin nFail++; $display("FAIL sleep_enter got=%0d exp=2", ctrl_state); end
    nTests++; if ((stall !== 5'b11111) || (flush !== 5'b00000)) begin
      nFail++; $display("FAIL sleep_ctrl got stall=%b flush=%b exp 11111/00000", stall, flush);
    end
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    nTests++; if (ctrl_state !== 2'd2) begin nFail++; $display("FAIL wfi_in_sleep got=%0d exp=2", ctrl_state); end
    irq_pending = 1'b1;
    tick();
    irq_pending = 1'b0;
    nTests++; if (ctrl_state !== 2'd3) begin nFail++; $display("FAIL wake_enter got=%0d exp=3", ctrl_state); end
    nTests++; if ((stall !== 5'b00000) || (flush !== 5'b00001)) begin
      nFail++; $display("FAIL wake_ctrl got stall=%b flush=%b exp 00000/00001", stall, flush);
    end
    tick();
    nTests++; if (ctrl_state !== 2'd0) begin nFail++; $display("FAIL wake_to_run got=%0d exp=0", ctrl_state); end
  endtask

  task automatic test_excp_sleep();
    stage_valid = 5'b00000;
    wfi_req     = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    nTests++; if (ctrl_state !== 2'd2) begin nFail++; $display("FAIL excp_pre_sleep got=%0d exp=2", ctrl_state); end
    excp_flag = 1'b1;
    #1;
    nTests++; if ((flush !== 5'b11111) || (stall !== 5'b00000)) begin
      nFail++; $display("FAIL excp_ctrl got stall=%b flush=%b exp 00000/11111", stall, flush);
    end
    tick();
    excp_flag = 1'b0;
    nTests++; if (ctrl_state !== 2'd0) begin nFail++; $display("FAIL excp_to_run got=%0d exp=0", ctrl_state); end
  endtask

  task automatic test_irq_drain();
    stage_valid = 5'b11110;
    wfi_req     = 1'b1;
    tick();
    wfi_req     = 1'b0;
    irq_pending = 1'b1;
    tick();
    irq_pending = 1'b0;
    nTests++; if (ctrl_state !== 2'd3) begin nFail++; $display("FAIL drain_irq got=%0d exp=3", ctrl_state); end
    tick();
    nTests++; if (ctrl_state !== 2'd0) begin nFail++; $display("FAIL drain_irq_run got=%0d exp=0", ctrl_state); end
  endtask

  task automatic test_rst_drain();
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    nTests++; if (ctrl_state !== 2'd1) begin nFail++; $display("FAIL rstd_pre got=%0d exp=1", ctrl_state); end
    rst = 1'b1;
    #1;
    nTests++; if ((flush !== 5'b11111) || (stall !== 5'b00000)) begin
      nFail++; $display("FAIL rstd_comb got stall=%b flush=%b exp 00000/11111", stall, flush);
    end
    tick();
    nTests++; if (ctrl_state !== 2'd0) begin nFail++; $display("FAIL rstd_state got=%0d exp=0", ctrl_state); end
    nTests++; if (stall_cycles !== 32'd0) begin nFail++; $display("FAIL rstd_cycles got=%0d exp=0", stall_cycles); end
    nTests++; if (flush !== 5'b11111) begin nFail++; $display("FAIL rstd_flush got=%b exp=11111", flush); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    stall_req    = '0;
    redirect_req = '0;
    excp_flag    = 1'b0;
    wfi_req      = 1'b0;
    stage_valid  = '0;
    irq_pending  = 1'b0;
    test_reset();
    test_stall_boundary();
    test_redirect();
    test_timeout();
    test_wfi_sleep();
    test_excp_sleep();
    test_irq_drain();
    test_rst_drain();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 5: number of pipeline registers controlled. Index 0 is youngest (IF/ID); index NUM_STAGES-1 is oldest (Mem/Wb).
REQ-002 Parameter TIMEOUT, default 255: consecutive stall cycles before a timeout pulse. Legal range 1..65535.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall_req  in  NUM_STAGES  bit i: stage i cannot advance this cycle.
REQ-006 redirect_req  in  NUM_STAGES  bit i: branch/jump resolved at stage i; younger contents are wrong-path.
REQ-007 excp_flag  in  1  exception/trap taken; whole pipeline is discarded.
REQ-008 wfi_req  in  1  single-cycle pulse: WFI instruction retired.
REQ-009 stage_valid  in  NUM_STAGES  bit i: register i holds a non-bubble instruction.
REQ-010 irq_pending  in  1  level: an enabled interrupt is pending.
REQ-011 stall  out  NUM_STAGES  bit k: hold pipeline register k.
REQ-012 flush  out  NUM_STAGES  bit k: load NOP/bubble into register k.
REQ-013 ctrl_state  out  2  FSM state: RUN=0, DRAIN=1, SLEEP=2, WAKE=3.
REQ-014 timeout_pulse  out  1  one-cycle pulse when TIMEOUT is reached.
REQ-015 stall_cycles  out  32  count of cycles with stall[0]=1, saturating.

Function
REQ-016 stall and flush SHALL be combinational from the current inputs and state; ctrl_state, counters and timeout_pulse SHALL be registered.
REQ-017 In RUN, stall[k] SHALL be 1 iff stall_req[j]=1 for any j>=k; an older stall holds all younger registers.
REQ-018 In RUN, a bubble SHALL be inserted at the stall boundary: flush[k]=1 when k>0, stall[k-1]=1 and stall[k]=0.
REQ-019 In RUN, flush[k] SHALL also be 1 when redirect_req[j]=1 for any j>k.
REQ-020 When flush[k]=1 from a redirect or exception, stall[k] SHALL be forced to 0; flush wins over stall for that register.
REQ-021 excp_flag=1 SHALL drive flush to all ones and stall to all zeros in any state. The next state SHALL be RUN, and the timeout counter SHALL clear.
REQ-022 RUN to DRAIN on wfi_req=1 with excp_flag=0. In DRAIN, stall[0]=1 and flush[1]=1 so no new fetches enter; older stages drain normally.
REQ-023 DRAIN to SLEEP when stage_valid[NUM_STAGES-1:1]==0.
REQ-024 SLEEP: stall all ones, flush all zeros. Exit to WAKE when irq_pending=1.
REQ-025 WAKE lasts exactly one cycle with flush[0]=1 and stall all zeros, then goes to RUN.
REQ-026 irq_pending=1 in DRAIN SHALL go directly to WAKE.
REQ-027 wfi_req outside RUN SHALL be ignored.
REQ-028 Timeout counter, width clog2(TIMEOUT+1):
- increments each RUN cycle with stall[0]=1;
- clears on any cycle with stall[0]=0 or in a non-RUN state;
- on reaching TIMEOUT, timeout_pulse=1 for the following cycle and the counter clears to 0.
REQ-029 stall_cycles SHALL increment on every cycle with stall[0]=1 in any state, saturating at 0xFFFFFFFF.
REQ-030 Simultaneous redirect_req at several stages: the union rule of REQ-019 applies, which is equivalent to the oldest redirect taking effect.

Reset
REQ-031 While rst=1, outputs SHALL be stall=0, flush=all ones, ctrl_state=RUN, timeout_pulse=0, stall_cycles=0, and the timeout counter SHALL be 0.
REQ-032 rst asserted in any state, including mid-DRAIN or SLEEP, SHALL return the block to RUN on the next edge with all counters cleared.
REQ-033 Registered values SHALL be fully defined one cycle after rst rises.

Verification
REQ-034 NUM_STAGES=5, stall_req=5'b00100 -> stall=5'b00111, flush=5'b01000.
REQ-035 stall_req=5'b00100 with redirect_req=5'b01000 in the same cycle -> flush=5'b00111, stall=5'b00000.
REQ-036 wfi_req pulse, then stage_valid falls to 5'b00000 three cycles later -> DRAIN for 3 cycles, then SLEEP (stall=5'b11111). Raising irq_pending -> one WAKE cycle with flush=5'b00001, then RUN.
REQ-037 TIMEOUT=4, stall_req[0] held high -> timeout_pulse high in the cycle after the 4th stall cycle; a further pulse 4 cycles later; stall_cycles counts every stalled cycle.
REQ-038 excp_flag asserted in SLEEP -> flush=5'b11111 that cycle, ctrl_state=RUN next cycle.
REQ-039 rst asserted mid-DRAIN -> ctrl_state=0, stall_cycles=0, flush=5'b11111 while rst=1.
